ysyx_22041211_dmem_slave: RTL

Memory-side responder for the core's load/store path. It accepts one masked read or write request at a time over a valid/ready handshake and holds it for a configurable access latency. It then commits the write or samples the read from an internal byte-enabled word array. Finally it returns a zero-extended read word, or a write acknowledgement, over a valid/ready response channel. It sits behind the LSU and replaces the single-cycle data SRAM, so multi-cycle memory timing can be exercised.

---
 rtl/ysyx_22041211_dmem_slave_pkg.sv | 31 +++
 rtl/ysyx_22041211_dmem_array.sv | 25 ++
 rtl/ysyx_22041211_dmem_slave.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041211_dmem_slave_pkg.sv
// Shared definitions for the data-memory slave.
// Mask and state codes are shared with the LSU.
package ysyx_22041211_dmem_slave_pkg;

  localparam logic [7:0] MEM_MASK_8  = 8'h01;
  localparam logic [7:0] MEM_MASK_16 = 8'h03;
  localparam logic [7:0] MEM_MASK_32 = 8'h0F;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } dmem_state_e;

  // Illegal size or misaligned offset; mask 0 is a legal no-op.
  function automatic logic mask_bad(
    input logic [7:0] mask,
    input logic [1:0] off
  );
    logic bad;
    case (mask)
      8'h00:       bad = 1'b0;
      MEM_MASK_8:  bad = 1'b0;
      MEM_MASK_16: bad = off[0];
      MEM_MASK_32: bad = |off;
      default:     bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ysyx_22041211_dmem_array.sv
// Word array with byte write enables.
// Synchronous write, combinational read.
module ysyx_22041211_dmem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [3:0]            we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ysyx_22041211_dmem_slave.sv
// Multi-cycle data memory responder behind the LSU.
// One request in flight; fixed latency; registered response.
module ysyx_22041211_dmem_slave
  import ysyx_22041211_dmem_slave_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter logic [ADDR_LEN-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [ADDR_LEN-1:0] req_addr_i,
  input  logic [DATA_LEN-1:0] req_wdata_i,
  input  logic [7:0]          req_mask_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_LEN-1:0] resp_rdata_o,
  output logic                resp_wr_o,
  output logic                resp_err_o
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [ADDR_LEN:0] LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_LEN:0] HI =
    LO + (ADDR_LEN+1)'(64'd4 << DEPTH_LOG2);

  dmem_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;

  logic                wen_q;
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [7:0]          mask_q;

  logic                valid_q, valid_n;
  logic [DATA_LEN-1:0] rdata_q, rdata_n;
  logic                wr_q, wr_n;
  logic                err_q, err_n;

  logic                  accept;
  logic                  fire;
  logic                  err;
  logic [1:0]            off;
  logic [ADDR_LEN-1:0]   rel;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            be;
  logic [3:0]            we;
  logic [DATA_LEN-1:0]   wr_word;
  logic [DATA_LEN-1:0]   rd_word;
  logic [DATA_LEN-1:0]   lanes;
  logic [DATA_LEN-1:0]   rd_data;

  assign req_ready_o  = (state == IDLE) & ~rst;
  assign accept       = req_valid_i & req_ready_o;
  assign resp_valid_o = valid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_wr_o    = wr_q;
  assign resp_err_o   = err_q;

  assign off = addr_q[1:0];
  assign rel = addr_q - BASE_ADDR;
  assign idx = DEPTH_LOG2'(rel >> 2);

  assign err = ({1'b0, addr_q} < LO)
             | ({1'b0, addr_q} >= HI)
             | mask_bad(mask_q, off);

  assign be      = 4'(mask_q[3:0] << off);
  assign wr_word = wdata_q << {off, 3'b000};

  // Gate with rst so a write pending at reset is dropped.
  assign we = (fire & wen_q & ~err & ~rst) ? be : 4'b0000;

  assign lanes = {{8{mask_q[3]}}, {8{mask_q[2]}},
                  {8{mask_q[1]}}, {8{mask_q[0]}}};
  assign rd_data = (rd_word >> {off, 3'b000}) & lanes;

  ysyx_22041211_dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .idx  (idx),
    .wdata(wr_word),
    .rdata(rd_word)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    valid_n = valid_q;
    rdata_n = rdata_q;
    wr_n    = wr_q;
    err_n   = err_q;
    fire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = WAIT;
          cnt_n   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          fire    = 1'b1;
          state_n = RESP;
          valid_n = 1'b1;
          wr_n    = wen_q;
          err_n   = err;
          rdata_n = (err | wen_q) ? '0 : rd_data;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_n = IDLE;
          valid_n = 1'b0;
          rdata_n = '0;
          wr_n    = 1'b0;
          err_n   = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      valid_q <= valid_n;
      rdata_q <= rdata_n;
      wr_q    <= wr_n;
      err_q   <= err_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      mask_q  <= req_mask_i;
    end
  end

endmodule
